fetch_redirect_unit: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core. Owns the PC register and the IF/ID pipeline register.
- Directly consumes PCSrc, the registered output of the Branch&Zero AND gate resolved in MEM.
- Arbitrates the next PC between branch redirect, jump, hazard stall, instruction-memory wait and sequential PC+4.
- Generates the pipeline flush strobes and a saturating branch-flush counter.

---
 rtl/fetch_redirect_unit_pkg.sv | 23 ++
 rtl/fetch_redirect_unit_sat_counter.sv | 22 ++
 rtl/fetch_redirect_unit.sv | 139 +++++++++++++
 tb/tb_fetch_redirect_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// datapath constants and the IF/ID register layout.
package fetch_redirect_unit_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [31:0] PC_INC          = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr & ~WORD_ALIGN_MASK) != 32'd0;
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  // Count up on inc until all-ones; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch stage: PC register, IF/ID register, next-PC arbitration,
// flush strobes and fetch statistics.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no fetch, everything held
// RUN   | fetching, PC advances when instruction memory is ready
// MISS  | instruction memory not ready, waiting with request held high
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PCSrc,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             Stall,
  input  logic             IMemReady,
  input  logic [31:0]      IMemInstr,
  output logic [31:0]      PC,
  output logic             IMemReq,
  output logic [31:0]      IFID_Instr,
  output logic [31:0]      IFID_PCPlus4,
  output logic             IFID_Valid,
  output logic             FlushIFID,
  output logic             FlushIDEX,
  output logic             FlushEXMEM,
  output logic             MissPending,
  output logic             Misaligned,
  output logic [CNT_W-1:0] FlushCount,
  output logic [CNT_W-1:0] MissCount
);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        active;
  logic        take_branch;
  logic        take_jump;
  logic        redirect_req;
  logic [31:0] pc_plus4;
  ifid_t       ifid_q;

  assign active       = (state_q != ST_BOOT);
  assign redirect_req = PCSrc | (Jump & ~Stall);
  assign take_branch  = active & PCSrc;
  assign take_jump    = active & ~PCSrc & Jump & ~Stall;
  assign pc_plus4     = PC + PC_INC;

  assign IMemReq     = active;
  assign MissPending = (state_q == ST_MISS);
  assign FlushIFID   = active & redirect_req;
  assign FlushIDEX   = take_branch;
  assign FlushEXMEM  = take_branch;

  assign IFID_Instr   = ifid_q.instr;
  assign IFID_PCPlus4 = ifid_q.pcplus4;
  assign IFID_Valid   = ifid_q.valid;

  // Next fetch state; a resolved branch ends a miss because the missing
  // fetch address is being abandoned anyway.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!IMemReady && !redirect_req) state_d = ST_MISS;
      ST_MISS: if (IMemReady || PCSrc) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // Fetch state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      state_q <= ST_BOOT;
    else
      state_q <= state_d;
  end

  // PC and IF/ID update in priority order: branch, stall, jump, fetch, bubble.
  // A bubble leaves PCPlus4 as-is since it is meaningless without Valid.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      PC             <= RESET_PC;
      ifid_q.instr   <= NOP_INSTR;
      ifid_q.pcplus4 <= 32'd0;
      ifid_q.valid   <= 1'b0;
    end else if (active) begin
      if (PCSrc) begin
        PC           <= BranchTarget & WORD_ALIGN_MASK;
        ifid_q.instr <= NOP_INSTR;
        ifid_q.valid <= 1'b0;
      end else if (Stall) begin
        PC     <= PC;
        ifid_q <= ifid_q;
      end else if (Jump) begin
        PC           <= JumpTarget & WORD_ALIGN_MASK;
        ifid_q.instr <= NOP_INSTR;
        ifid_q.valid <= 1'b0;
      end else if (IMemReady) begin
        PC             <= pc_plus4;
        ifid_q.instr   <= IMemInstr;
        ifid_q.pcplus4 <= pc_plus4;
        ifid_q.valid   <= 1'b1;
      end else begin
        ifid_q.instr <= NOP_INSTR;
        ifid_q.valid <= 1'b0;
      end
    end
  end

  // Sticky flag for any accepted redirect to a non-word-aligned target.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      Misaligned <= 1'b0;
    else if ((take_branch && is_misaligned(BranchTarget)) ||
             (take_jump && is_misaligned(JumpTarget)))
      Misaligned <= 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .inc   (take_branch),
    .clear (1'b0),
    .count (FlushCount)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .inc   (IMemReq & ~IMemReady),
    .clear (1'b0),
    .count (MissCount)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed vector table, corner-case
// sequences, then randomized stimulus against a behavioural model.
module tb_fetch_redirect_unit;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             Clk = 1'b0;
  logic             Rst;
  logic             PCSrc, Jump, Stall, IMemReady;
  logic [31:0]      BranchTarget, JumpTarget, IMemInstr;
  logic [31:0]      PC, IFID_Instr, IFID_PCPlus4;
  logic             IMemReq, IFID_Valid, FlushIFID, FlushIDEX, FlushEXMEM;
  logic             MissPending, Misaligned;
  logic [CNT_W-1:0] FlushCount, MissCount;

  fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Stall(Stall),
    .IMemReady(IMemReady), .IMemInstr(IMemInstr), .PC(PC),
    .IMemReq(IMemReq), .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX),
    .FlushEXMEM(FlushEXMEM), .MissPending(MissPending),
    .Misaligned(Misaligned), .FlushCount(FlushCount), .MissCount(MissCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [31:0] bt, input logic j,
                       input logic [31:0] jt, input logic s, input logic r,
                       input logic [31:0] ins);
    PCSrc = p; BranchTarget = bt; Jump = j; JumpTarget = jt;
    Stall = s; IMemReady = r; IMemInstr = ins;
  endtask

  task automatic edge_step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        p;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        s;
    logic        r;
    logic [31:0] ins;
    logic        e_fifid;
    logic        e_fbr;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcp4;
  } vec_t;

  function automatic vec_t mk(input logic p, input logic [31:0] bt, input logic j,
                              input logic [31:0] jt, input logic s, input logic r,
                              input logic [31:0] ins, input logic e_fifid,
                              input logic e_fbr, input logic [31:0] e_pc,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pcp4);
    vec_t v;
    v.p = p; v.bt = bt; v.j = j; v.jt = jt; v.s = s; v.r = r; v.ins = ins;
    v.e_fifid = e_fifid; v.e_fbr = e_fbr; v.e_pc = e_pc; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pcp4 = e_pcp4;
    return v;
  endfunction

  // Behavioural reference: plain variables describing what the fetch stage
  // should hold, advanced one clock at a time from the stated rules.
  logic             m_boot, m_wait;
  logic [31:0]      m_pc, m_instr, m_pcp4;
  logic             m_valid, m_mis;
  int unsigned      m_fcnt, m_mcnt;

  task automatic model_reset();
    m_boot = 1; m_wait = 0; m_pc = 0; m_instr = 0; m_pcp4 = 0;
    m_valid = 0; m_mis = 0; m_fcnt = 0; m_mcnt = 0;
  endtask

  task automatic model_clock();
    logic redirect;
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    redirect = PCSrc || (Jump && !Stall);
    if (!IMemReady && m_mcnt < 2**CNT_W - 1) m_mcnt++;
    if (m_wait) m_wait = !(IMemReady || PCSrc);
    else        m_wait = !IMemReady && !redirect;
    if (PCSrc) begin
      m_pc = {BranchTarget[31:2], 2'b00};
      m_instr = 0; m_valid = 0;
      if (m_fcnt < 2**CNT_W - 1) m_fcnt++;
      if (BranchTarget % 4 != 0) m_mis = 1;
    end else if (Stall) begin
      // everything held
    end else if (Jump) begin
      m_pc = {JumpTarget[31:2], 2'b00};
      m_instr = 0; m_valid = 0;
      if (JumpTarget % 4 != 0) m_mis = 1;
    end else if (IMemReady) begin
      m_pc = m_pc + 4;
      m_pcp4 = m_pc;
      m_instr = IMemInstr; m_valid = 1;
    end else begin
      m_instr = 0; m_valid = 0;
    end
  endtask

  task automatic model_compare();
    logic act_up;
    act_up = !m_boot;
    check("rnd_pc", PC, m_pc);
    check("rnd_req", {31'd0, IMemReq}, {31'd0, act_up});
    check("rnd_miss", {31'd0, MissPending}, {31'd0, m_wait});
    check("rnd_valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
    check("rnd_instr", IFID_Instr, m_instr);
    if (m_valid) check("rnd_pcp4", IFID_PCPlus4, m_pcp4);
    check("rnd_misal", {31'd0, Misaligned}, {31'd0, m_mis});
    check("rnd_fcnt", 32'(FlushCount), m_fcnt);
    check("rnd_mcnt", 32'(MissCount), m_mcnt);
    check("rnd_fifid", {31'd0, FlushIFID}, {31'd0, act_up && (PCSrc || (Jump && !Stall))});
    check("rnd_fidex", {31'd0, FlushIDEX}, {31'd0, act_up && PCSrc});
    check("rnd_fexmem", {31'd0, FlushEXMEM}, {31'd0, act_up && PCSrc});
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 1, 32'h1000, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 32'h1000, 0, 0, 32'h4, 1, 32'h1000, 32'h4);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 32'h1001, 0, 0, 32'h8, 1, 32'h1001, 32'h8);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 32'h1002, 0, 0, 32'hC, 1, 32'h1002, 32'hC);
    vecs[4]  = mk(1, 32'h400, 1, 32'h800, 1, 1, 32'hDEAD, 1, 1, 32'h400, 0, 32'h0, 32'h0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 32'h5555, 0, 0, 32'h404, 1, 32'h5555, 32'h404);
    vecs[6]  = mk(0, 0, 1, 32'h2000, 1, 1, 32'h6666, 0, 0, 32'h404, 1, 32'h5555, 32'h404);
    vecs[7]  = mk(0, 0, 1, 32'h2000, 1, 1, 32'h6666, 0, 0, 32'h404, 1, 32'h5555, 32'h404);
    vecs[8]  = mk(0, 0, 1, 32'h2000, 1, 1, 32'h6666, 0, 0, 32'h404, 1, 32'h5555, 32'h404);
    vecs[9]  = mk(0, 0, 1, 32'h2000, 0, 1, 32'h7777, 1, 0, 32'h2000, 0, 32'h0, 32'h0);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 32'hAAAA, 0, 0, 32'h2004, 1, 32'hAAAA, 32'h2004);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h2004, 0, 32'h0, 32'h0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 32'hBBBB, 0, 0, 32'h2008, 1, 32'hBBBB, 32'h2008);

    Rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    edge_step();
    edge_step();
    check("rst_pc", PC, 32'h0);
    check("rst_valid", {31'd0, IFID_Valid}, 32'd0);
    check("rst_req", {31'd0, IMemReq}, 32'd0);
    Rst = 1'b1;

    // Directed vector table starting in BOOT.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].p, vecs[i].bt, vecs[i].j, vecs[i].jt, vecs[i].s, vecs[i].r, vecs[i].ins);
      #1;
      check($sformatf("v%0d_flushifid", i), {31'd0, FlushIFID}, {31'd0, vecs[i].e_fifid});
      check($sformatf("v%0d_flushidex", i), {31'd0, FlushIDEX}, {31'd0, vecs[i].e_fbr});
      check($sformatf("v%0d_flushexmem", i), {31'd0, FlushEXMEM}, {31'd0, vecs[i].e_fbr});
      edge_step();
      check($sformatf("v%0d_pc", i), PC, vecs[i].e_pc);
      check($sformatf("v%0d_valid", i), {31'd0, IFID_Valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_instr", i), IFID_Instr, vecs[i].e_instr);
      if (vecs[i].e_valid)
        check($sformatf("v%0d_pcp4", i), IFID_PCPlus4, vecs[i].e_pcp4);
    end
    check("tbl_fcnt", 32'(FlushCount), 32'd1);
    check("tbl_mcnt", 32'(MissCount), 32'd1);

    // Four-cycle miss at 0x40.
    drive(1, 32'h40, 0, 0, 0, 1, 0);
    edge_step();
    check("miss_setup_pc", PC, 32'h40);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      edge_step();
      check("miss_pending", {31'd0, MissPending}, 32'd1);
      check("miss_pc_hold", PC, 32'h40);
      check("miss_valid", {31'd0, IFID_Valid}, 32'd0);
    end
    check("miss_count", 32'(MissCount), 32'd5);
    drive(0, 0, 0, 0, 0, 1, 32'hCCCC);
    edge_step();
    check("miss_exit_pc", PC, 32'h44);
    check("miss_exit_pending", {31'd0, MissPending}, 32'd0);
    check("miss_exit_instr", IFID_Instr, 32'hCCCC);

    // PC wrap at the top of the address space.
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 0);
    edge_step();
    check("wrap_setup_pc", PC, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 1, 32'h1234);
    edge_step();
    check("wrap_pc", PC, 32'h0);
    check("wrap_pcp4", IFID_PCPlus4, 32'h0);
    check("wrap_valid", {31'd0, IFID_Valid}, 32'd1);

    // Misaligned branch target is truncated and flagged stickily.
    check("misal_before", {31'd0, Misaligned}, 32'd0);
    drive(1, 32'h0000_0102, 0, 0, 0, 1, 0);
    edge_step();
    check("misal_pc", PC, 32'h100);
    check("misal_set", {31'd0, Misaligned}, 32'd1);
    drive(0, 0, 0, 0, 0, 1, 32'h1);
    edge_step();
    edge_step();
    check("misal_sticky", {31'd0, Misaligned}, 32'd1);
    check("misal_pc_adv", PC, 32'h108);
    check("flush_cnt4", 32'(FlushCount), 32'd4);

    // Saturate FlushCount then branch once more.
    for (int i = 0; i < 11; i++) begin
      drive(1, 32'h10, 0, 0, 0, 1, 0);
      edge_step();
    end
    check("sat_reached", 32'(FlushCount), 32'(CNT_MAX));
    drive(1, 32'h20, 0, 0, 0, 1, 0);
    edge_step();
    check("sat_hold", 32'(FlushCount), 32'(CNT_MAX));

    // Asynchronous reset in the middle of a miss.
    drive(0, 0, 0, 0, 0, 0, 0);
    edge_step();
    edge_step();
    check("arst_pre_miss", {31'd0, MissPending}, 32'd1);
    drive(1, 32'h300, 1, 32'h500, 0, 0, 0);
    #2;
    Rst = 1'b0;
    #1;
    check("arst_pc", PC, 32'h0);
    check("arst_instr", IFID_Instr, 32'h0);
    check("arst_pcp4", IFID_PCPlus4, 32'h0);
    check("arst_valid", {31'd0, IFID_Valid}, 32'd0);
    check("arst_miss", {31'd0, MissPending}, 32'd0);
    check("arst_req", {31'd0, IMemReq}, 32'd0);
    check("arst_misal", {31'd0, Misaligned}, 32'd0);
    check("arst_fcnt", 32'(FlushCount), 32'd0);
    check("arst_mcnt", 32'(MissCount), 32'd0);
    check("arst_flush", {29'd0, FlushIFID, FlushIDEX, FlushEXMEM}, 32'd0);

    // Randomized run against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0);
    edge_step();
    Rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 19) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 19) != 0) jt[1:0] = 2'b00;
      drive($urandom_range(0, 9) == 0, bt, $urandom_range(0, 6) == 0, jt,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, $urandom);
      #1;
      model_compare();
      @(posedge Clk);
      model_clock();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
